// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter and fixed-latency access sequencer for the shared CPU memory port.
// Fetch and load/store requests are granted round-robin and held stable for MEM_LATENCY cycles.

// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no access in flight; sample ifReq/dReq and grant one
// S_ACCESS| latched address/data/control driven to memory, counter runs
// S_DONE  | one-cycle done pulse to the granted requester
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifReq,
    input  logic [ADDR_WIDTH-1:0] ifAddr,
    output logic [DATA_WIDTH-1:0] ifRdata,
    output logic                  ifDone,

    input  logic                  dReq,
    input  logic                  dWe,
    input  logic [ADDR_WIDTH-1:0] dAddr,
    input  logic [DATA_WIDTH-1:0] dWdata,
    output logic [DATA_WIDTH-1:0] dRdata,
    output logic                  dDone,

    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWdata,
    output logic                  memRead,
    output logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] memRdata,

    output logic                  busy,
    output logic                  grantId
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  pick_data;
    logic                  final_cycle;

    assign final_cycle = (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;  // data counts as served last, so fetch wins the first conflict
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        grant_d    = grant_q;
        last_d     = last_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        pick_data  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ifReq || dReq) begin
                    // On conflict, serve whoever was not served last.
                    pick_data = dReq && (!ifReq || !last_q);
                    grant_d   = pick_data;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_ACCESS;
                    if (pick_data) begin
                        addr_d  = dAddr;
                        we_d    = dWe;
                        wdata_d = dWdata;
                    end else begin
                        addr_d  = ifAddr;
                        we_d    = 1'b0;
                    end
                end
            end

            S_ACCESS: begin
                if (final_cycle) begin
                    if (!we_q) begin
                        if (grant_q) d_rdata_d  = memRdata;
                        else         if_rdata_d = memRdata;
                    end
                    last_d  = grant_q;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A store writes only on the last access cycle so the memory sees exactly one write.
    assign memRead  = (state_q == S_ACCESS) && !we_q;
    assign memWrite = (state_q == S_ACCESS) && we_q && final_cycle;
    assign memAddr  = addr_q;
    assign memWdata = wdata_q;

    assign ifDone   = (state_q == S_DONE) && !grant_q;
    assign dDone    = (state_q == S_DONE) && grant_q;
    assign busy     = (state_q == S_ACCESS) || (state_q == S_DONE);
    assign grantId  = grant_q;
    assign ifRdata  = if_rdata_q;
    assign dRdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected read data,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifDone;
    logic        dReq;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;
    logic [31:0] dRdata;
    logic        dDone;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memRdata;
    logic        busy;
    logic        grantId;

    // second instance, MEM_LATENCY=3, used for the reset-mid-store case
    logic        rst_n3;
    logic        dReq3;
    logic        dWe3;
    logic [31:0] dAddr3;
    logic [31:0] dWdata3;
    logic [31:0] ifRdata3, dRdata3, memAddr3, memWdata3;
    logic        ifDone3, dDone3, memRead3, memWrite3, busy3, grantId3;
    logic [31:0] mem3_84;

    logic [31:0] mem [0:255];

    int n_vec = 0;
    int n_fail = 0;
    int rd_cycles = 0;
    int wr_cycles = 0;
    int wr3_cycles = 0;
    int if_done_cnt = 0;
    int d_done_cnt = 0;
    logic [31:0] qi [$];
    logic [31:0] qd [$];
    logic        grant_log [$];

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifDone(ifDone),
        .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dDone(dDone),
        .memAddr(memAddr), .memWdata(memWdata), .memRead(memRead), .memWrite(memWrite),
        .memRdata(memRdata), .busy(busy), .grantId(grantId)
    );

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3),
        .ifReq(1'b0), .ifAddr(32'd0), .ifRdata(ifRdata3), .ifDone(ifDone3),
        .dReq(dReq3), .dWe(dWe3), .dAddr(dAddr3), .dWdata(dWdata3), .dRdata(dRdata3), .dDone(dDone3),
        .memAddr(memAddr3), .memWdata(memWdata3), .memRead(memRead3), .memWrite(memWrite3),
        .memRdata(32'd0), .busy(busy3), .grantId(grantId3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memRdata = memRead ? mem[memAddr[7:0]] : 32'd0;

    always @(posedge clk) begin
        if (memWrite) mem[memAddr[7:0]] <= memWdata;
        if (memWrite3 && memAddr3 == 32'd84) mem3_84 <= memWdata3;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (memRead) rd_cycles++;
        if (memWrite) begin
            wr_cycles++;
            check("write_excludes_read", 32'(memRead), 32'd0);
        end
        if (memWrite3) wr3_cycles++;
        if (ifDone) begin
            if_done_cnt++;
            grant_log.push_back(1'b0);
            check("if_done_pending", 32'(qi.size() != 0), 32'd1);
            check("if_done_grantId", 32'(grantId), 32'd0);
            if (qi.size() != 0) begin
                e = qi.pop_front();
                check("ifRdata", ifRdata, e);
            end
        end
        if (dDone) begin
            d_done_cnt++;
            grant_log.push_back(1'b1);
            check("d_done_pending", 32'(qd.size() != 0), 32'd1);
            check("d_done_grantId", 32'(grantId), 32'd1);
            if (qd.size() != 0) begin
                e = qd.pop_front();
                check("dRdata", dRdata, e);
            end
        end
    end

    task automatic req_if(input logic [31:0] a, input logic [31:0] e);
        int n;
        qi.push_back(e);
        @(negedge clk);
        ifReq  = 1'b1;
        ifAddr = a;
        n = 0;
        while (!ifDone && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("if_done_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 ifReq = 1'b0;
    endtask

    task automatic req_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] e);
        int n;
        qd.push_back(e);
        @(negedge clk);
        dReq   = 1'b1;
        dWe    = we;
        dAddr  = a;
        dWdata = wd;
        n = 0;
        while (!dDone && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("d_done_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 dReq = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0, dd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[80] = 32'd8;
        mem[81] = 32'd44;
        mem[82] = 32'd432;
        mem3_84 = 32'd0;
        rst_n = 1'b0; rst_n3 = 1'b0;
        ifReq = 1'b0; ifAddr = 32'd0;
        dReq = 1'b0; dWe = 1'b0; dAddr = 32'd0; dWdata = 32'd0;
        dReq3 = 1'b0; dWe3 = 1'b0; dAddr3 = 32'd0; dWdata3 = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; rst_n3 = 1'b1;

        // reset then idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ctl", {26'd0, ifDone, dDone, memRead, memWrite, busy, grantId}, 32'd0);
            check("idle_data", memAddr | memWdata | ifRdata | dRdata, 32'd0);
        end

        // single fetch with cycle-accurate window
        qi.push_back(32'd8);
        @(negedge clk);
        ifReq = 1'b1; ifAddr = 32'd80;
        @(negedge clk);
        check("fetch_c1_read", 32'(memRead), 32'd1);
        check("fetch_c1_addr", memAddr, 32'd80);
        check("fetch_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("fetch_c2_read", 32'(memRead), 32'd1);
        check("fetch_c2_done", 32'(ifDone), 32'd0);
        @(negedge clk);
        check("fetch_c3_done", 32'(ifDone), 32'd1);
        check("fetch_c3_read", 32'(memRead), 32'd0);
        @(posedge clk);
        #1 ifReq = 1'b0;
        @(negedge clk);
        check("fetch_after_busy", 32'(busy), 32'd0);
        check("fetch_ifRdata_hold", ifRdata, 32'd8);

        // store then load
        wr0 = wr_cycles;
        req_d(1'b1, 32'd85, 32'hFFFF_FFFE, 32'd0);
        check("store_write_cycles", 32'(wr_cycles - wr0), 32'd1);
        check("store_mem85", mem[85], 32'hFFFF_FFFE);
        req_d(1'b0, 32'd85, 32'd0, 32'hFFFF_FFFE);
        check("load_ifRdata_unchanged", ifRdata, 32'd8);

        // simultaneous requests, four conflicts, grants must alternate
        do_reset();
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            fork
                req_if(32'd81, 32'd44);
                req_d(1'b0, 32'd82, 32'd0, 32'd432);
            join
        end
        check("conflict_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < grant_log.size(); i++)
            check("conflict_order", 32'(grant_log[i]), 32'(i % 2));

        // reset during first ACCESS cycle of a store, latency 3
        @(negedge clk);
        dReq3 = 1'b1; dWe3 = 1'b1; dAddr3 = 32'd84; dWdata3 = 32'd7;
        @(posedge clk);
        #1;
        check("mid_store_busy", 32'(busy3), 32'd1);
        rst_n3 = 1'b0;
        #1;
        check("mid_store_rst_write", 32'(memWrite3), 32'd0);
        check("mid_store_rst_busy", 32'(busy3), 32'd0);
        dReq3 = 1'b0;
        @(negedge clk);
        rst_n3 = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_store_writes", 32'(wr3_cycles), 32'd0);
        check("mid_store_mem84", mem3_84, 32'd0);
        check("mid_store_idle", {30'd0, busy3, dDone3}, 32'd0);
        check("mid_store_grant", 32'(grantId3), 32'd0);

        // request dropped one cycle after the grant
        rd0 = rd_cycles;
        dd0 = d_done_cnt;
        qd.push_back(32'd432);
        @(negedge clk);
        dReq = 1'b1; dWe = 1'b0; dAddr = 32'd82;
        @(posedge clk);
        @(posedge clk);
        #1 dReq = 1'b0;
        repeat (10) @(negedge clk);
        check("drop_done_count", 32'(d_done_cnt - dd0), 32'd1);
        check("drop_read_cycles", 32'(rd_cycles - rd0), 32'd2);
        check("drop_idle", 32'(busy), 32'd0);

        check("if_queue_drained", 32'(qi.size()), 32'd0);
        check("d_queue_drained", 32'(qd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the single shared memory port of the multicycle CPU. It grants either the instruction-fetch requester or the load/store requester, holds address, data and control stable for a fixed number of memory cycles, returns read data, and pulses a per-requester done. Its memory-side outputs connect directly to the `dataMemory` port:
- `memRead` and `memWrite` drive that port's read and write enables.
- The memory's read data is combinational while `memRead` is high.
- The memory writes on the clock edge while `memWrite` is high.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- MEM_LATENCY, 2, memory cycles per access; legal range is 1..15

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- ifReq  in  1  fetch request, level; held until ifDone is seen
- ifAddr  in  ADDR_WIDTH  fetch address
- ifRdata  out  DATA_WIDTH  last fetched word, registered
- ifDone  out  1  one-cycle completion pulse for fetch
- dReq  in  1  load/store request, level; held until dDone is seen
- dWe  in  1  1 = store, 0 = load
- dAddr  in  ADDR_WIDTH  load/store address
- dWdata  in  DATA_WIDTH  store data
- dRdata  out  DATA_WIDTH  last loaded word, registered
- dDone  out  1  one-cycle completion pulse for load/store
- memAddr  out  ADDR_WIDTH  shared memory address
- memWdata  out  DATA_WIDTH  shared memory write data
- memRead  out  1  memory read enable
- memWrite  out  1  memory write enable
- memRdata  in  DATA_WIDTH  memory read data, combinational
- busy  out  1  high in ACCESS and DONE
- grantId  out  1  owner of the current or last access; 0 = fetch, 1 = data

## Operation
- There are three states: IDLE, ACCESS and DONE.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one of ifReq/dReq is high, grant it.
  - If both are high, grant the requester that was not served last (round-robin pointer `lastServed`).
  - On grant, latch the address; for the data requester also latch dWe and dWdata.
  - Set grantId, load the counter with MEM_LATENCY-1 and go to ACCESS.
- ACCESS:
  - memAddr and memWdata come from the latched registers and stay stable.
  - For a read, memRead = 1 on every ACCESS cycle.
  - For a store, memWrite = 1 only on the final ACCESS cycle (counter == 0), so exactly one memory write occurs per store.
  - The counter decrements each cycle.
  - On the final cycle of a read, memRdata is captured into ifRdata or dRdata according to grantId.
  - After the final cycle, go to DONE and update `lastServed` to grantId.
- DONE:
  - The granted requester's done output = 1 for this single cycle; then go to IDLE.
- Fetch is always a read. ifReq does not use dWe.
- A store leaves dRdata unchanged. ifRdata and dRdata hold their value until the next completed read by the same requester.
- If a requester drops its req mid-access, the access is not aborted. It completes and done still pulses.
- Outside ACCESS: memRead = memWrite = 0, and memAddr/memWdata hold their last values.
- Reset (asynchronous, may occur mid-access):
  - State returns to IDLE.
  - memRead, memWrite, ifDone, dDone and busy go to 0 immediately.
  - memAddr, memWdata, ifRdata, dRdata and grantId go to 0.
  - `lastServed` is set to data, so fetch wins the first conflict.
  - An interrupted store does not write.

## Timing
- The request is sampled in IDLE at edge E0.
- ACCESS occupies the cycles after E0 through E0+MEM_LATENCY.
- The done pulse falls in the cycle after that.
- Total request-to-done latency is MEM_LATENCY+1 cycles. With MEM_LATENCY=2, a request seen at cycle 0 gives done in cycle 3.
- The next grant can occur no earlier than the IDLE cycle following DONE. Back-to-back throughput is therefore one access per MEM_LATENCY+2 cycles.
- A requester must deassert req on the edge that ends its done cycle. A req still high in IDLE is treated as a new request.
- Request inputs are ignored in ACCESS and DONE. A request arriving during an access waits; none is lost while req is held.
- MEM_LATENCY=1: ACCESS lasts one cycle, and for a store memWrite is high in that cycle.

## Test plan
- Reset then idle:
  - Stimulus: rst_n low, then released with no requests.
  - Required: all outputs 0 and busy 0 for 10 cycles.
- Single fetch:
  - Stimulus: bench memory word 80 = 8; ifReq=1 with ifAddr=80 at cycle 0; MEM_LATENCY=2.
  - Required: memRead high in cycles 1–2; ifDone pulses in cycle 3; ifRdata = 8; dDone stays 0.
- Store then load:
  - Stimulus: dReq with dWe=1, dAddr=85, dWdata=0xFFFFFFFE; then a load from 85.
  - Required: memWrite high for exactly 1 cycle; the load returns dRdata = 0xFFFFFFFE; ifRdata is unchanged.
- Simultaneous requests:
  - Stimulus: after reset, ifReq=1 (addr 81, word 44) and dReq=1 (load addr 82, word 432) asserted together and held until done.
  - Required: fetch is served first with ifRdata = 44; the data access follows and returns dRdata = 432. Over 4 repeated conflicts the grants alternate.
- Reset mid-store:
  - Stimulus: a store to address 84 with value 7 is started; rst_n is asserted during its first ACCESS cycle, MEM_LATENCY=3.
  - Required: memWrite never goes high, memory word 84 is unchanged, and the FSM is in IDLE after reset.
- Request dropped mid-access:
  - Stimulus: dReq is deasserted one cycle after the grant.
  - Required: the access completes, dDone pulses once, and no second access starts.
